phase_measure: RTL
==================

PHASE_MEASURE -- requirements
Module: phase_measure

Interface
REQ-001 Parameter HALF_PERIOD, default 626, SHALL be the half period of the input square waves in clk cycles (full period 2*HALF_PERIOD = 1252).
REQ-002 Parameter LOCK_COUNT, default 4, SHALL be the number of consecutive consistent measurements required to assert locked.
REQ-003 Parameter NOREF_LIMIT, default 4095, SHALL be the number of cycles without a reference edge before no_ref asserts.
REQ-004 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 ref_in  input  1  SHALL be the unshifted reference square wave (asynchronous).
REQ-007 sig_in  input  1  SHALL be the phase-shifted square wave to be measured (asynchronous).
REQ-008 delay_out  output  11 signed  SHALL be the last measured delay of sig_in relative to ref_in, in clk cycles.
REQ-009 valid  output  1  SHALL pulse high for one cycle when delay_out updates.
REQ-010 miss  output  1  SHALL pulse high for one cycle when a reference period passes without a sig_in rising edge.
REQ-011 no_ref  output  1  SHALL be high while no ref_in rising edge has been seen for NOREF_LIMIT cycles.
REQ-012 locked  output  1  SHALL be high while the measurement is stable.

Function
REQ-013 ref_in and sig_in SHALL each pass through an identical 2-flop synchronizer, then a rising-edge detector (ref_rise, sig_rise), so relative timing is preserved.
REQ-014 FSM SHALL have states IDLE and MEASURE; reset state SHALL be IDLE.
REQ-015 IDLE: on ref_rise -> MEASURE, 12-bit unsigned counter cleared to 0; otherwise remain.
REQ-016 MEASURE: counter SHALL increment by 1 each cycle; raw SHALL equal the number of cycles from the ref_rise cycle to the sig_rise cycle.
REQ-017 On sig_rise in MEASURE: delay_out SHALL be raw if raw <= HALF_PERIOD, else raw - 2*HALF_PERIOD (range -625..+626); valid SHALL pulse in the cycle after sig_rise; FSM -> IDLE.
REQ-018 ref_rise and sig_rise in the same cycle while in IDLE SHALL produce delay_out = 0, with valid pulsing next cycle and FSM staying in IDLE.
REQ-019 ref_rise in MEASURE without sig_rise SHALL pulse miss, leave delay_out unchanged, clear the counter to 0, and stay in MEASURE.
REQ-020 ref_rise and sig_rise together in MEASURE SHALL complete the current measurement (valid) and immediately start a new one (counter = 0, stay in MEASURE); this SHALL NOT produce a miss.
REQ-021 The counter SHALL saturate at 4095 and never wrap.
REQ-022 A separate no-ref counter SHALL clear on every ref_rise and otherwise increment, saturating; no_ref = 1 when it reaches NOREF_LIMIT; on no_ref the FSM SHALL return to IDLE.
REQ-023 Lock counter: on each valid, if |new - previous delay_out| <= 1, increment (saturate at LOCK_COUNT), else set to 1.
REQ-024 locked = 1 when the lock counter equals LOCK_COUNT.
REQ-025 miss or no_ref assertion SHALL clear the lock counter to 0 and deassert locked in the next cycle.
REQ-026 The first valid after reset SHALL set the lock counter to 1.

Reset
REQ-027 rst high at a clk edge SHALL force: FSM IDLE, synchronizers 0, counters 0, delay_out 0, valid 0, miss 0, no_ref 0, locked 0.
REQ-028 Reset asserted mid-MEASURE SHALL discard the measurement with no valid or miss pulse.
REQ-029 After rst deasserts, the first ref_rise SHALL start a fresh measurement.

Verification
REQ-030 ref and sig both toggling every 626 cycles, sig lagging ref by 100 cycles -> valid once per 1252 cycles, delay_out = +100, locked after the 4th valid.
REQ-031 sig lagging ref by 1152 cycles (leading by 100) -> delay_out = -100.
REQ-032 sig identical to ref -> delay_out = 0 every period, no miss.
REQ-033 sig held at 0 with ref toggling -> miss pulses once per 1252 cycles, valid never pulses, locked = 0.
REQ-034 ref held at 0 -> no_ref = 1 after 4095 cycles; resuming ref clears no_ref on the first ref_rise.
REQ-035 Lag stepped from 100 to 300 while locked -> locked drops the cycle after the mismatching valid and re-asserts after 3 further valids at 300; rst mid-MEASURE -> all outputs 0, no pulses.

Source files
------------

// File: rtl/phase_measure.sv
// phase_measure: measures the delay of sig_in relative to ref_in in clk cycles, with lock and loss-of-reference flags
module phase_measure #(
  parameter int HALF_PERIOD = 626,
  parameter int LOCK_COUNT  = 4,
  parameter int NOREF_LIMIT = 4095
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ref_in,
  input  logic               sig_in,
  output logic signed [10:0] delay_out,
  output logic               valid,
  output logic               miss,
  output logic               no_ref,
  output logic               locked
);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t             r_state;
  logic [1:0]         r_ref_s, r_sig_s;
  logic               r_ref_d, r_sig_d, r_valid, r_miss;
  logic [11:0]        r_cnt, r_nrc;
  logic [LW-1:0]      r_lc;
  logic signed [10:0] r_delay, r_prev;
  logic               w_ref_rise, w_sig_rise, w_meas, w_done, w_close;
  logic [11:0]        w_raw;
  logic [10:0]        w_wrap;
  logic signed [10:0] w_delay;
  logic signed [12:0] w_step;
  assign delay_out = r_delay;
  assign valid     = r_valid;
  assign miss      = r_miss;
  assign no_ref    = r_nrc == 12'(NOREF_LIMIT);
  assign locked    = r_lc == LW'(LOCK_COUNT);
  always_comb begin
    w_ref_rise = r_ref_s[1] & ~r_ref_d;
    w_sig_rise = r_sig_s[1] & ~r_sig_d;
    w_meas     = r_state == MEASURE;
    w_done     = w_sig_rise & (w_meas | w_ref_rise);
    w_raw      = !w_meas ? 12'd0 : (&r_cnt) ? r_cnt : r_cnt + 12'd1;
    w_wrap     = w_raw[10:0] - 11'(2 * HALF_PERIOD);
    w_delay    = (w_raw <= 12'(HALF_PERIOD)) ? w_raw[10:0] : w_wrap;
    w_step     = {{2{r_delay[10]}}, r_delay} - {{2{r_prev[10]}}, r_prev};
    w_close    = w_step >= -13'sd1 && w_step <= 13'sd1;
  end
  // r_cnt holds raw-1 so the sig_rise cycle reads raw as r_cnt+1; lock is judged the cycle after valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ref_s <= '0;
      r_sig_s <= '0;
      r_ref_d <= 1'b0;
      r_sig_d <= 1'b0;
      r_cnt   <= '0;
      r_nrc   <= '0;
      r_lc    <= '0;
      r_delay <= '0;
      r_prev  <= '0;
      r_valid <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_ref_s <= {r_ref_s[0], ref_in};
      r_sig_s <= {r_sig_s[0], sig_in};
      r_ref_d <= r_ref_s[1];
      r_sig_d <= r_sig_s[1];
      r_state <= w_ref_rise ? ((w_meas || !w_sig_rise) ? MEASURE : IDLE) : (w_sig_rise || no_ref) ? IDLE : r_state;
      r_cnt   <= w_ref_rise ? 12'd0 : w_raw;
      r_nrc   <= w_ref_rise ? 12'd0 : no_ref ? r_nrc : r_nrc + 12'd1;
      r_valid <= w_done;
      r_miss  <= w_meas & w_ref_rise & ~w_sig_rise;
      if (w_done) begin
        r_prev  <= r_delay;
        r_delay <= w_delay;
      end
      if (r_miss || no_ref) r_lc <= '0;
      else if (r_valid) r_lc <= !w_close ? LW'(1) : locked ? r_lc : r_lc + LW'(1);
    end
  end
endmodule
